// File: rtl/debouncer_multi.sv
// Multi-channel key debouncer: 2-FF sync, glitch filter, press/release/hold strobes.
// Each channel is independent; every output is driven straight from a register.
module debouncer_multi #(
    parameter int CHANNELS       = 4,
    parameter int CLK_FREQ_MHZ   = 100,
    parameter int GLITCH_TIME_NS = 150,
    parameter int ACTIVE_LOW     = 1,
    parameter int HOLD_TIME_US   = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] key_i,
    output logic [CHANNELS-1:0] key_state_o,
    output logic [CHANNELS-1:0] key_pressed_stb_o,
    output logic [CHANNELS-1:0] key_released_stb_o,
    output logic [CHANNELS-1:0] key_held_stb_o
);

    localparam int G  = (CLK_FREQ_MHZ * GLITCH_TIME_NS + 999) / 1000;
    localparam int H  = CLK_FREQ_MHZ * HOLD_TIME_US;
    localparam int GW = $clog2(G + 1);

    localparam logic [GW-1:0]       G_LAST = GW'(G - 1);
    localparam logic [CHANNELS-1:0] IDLE   = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CHANNELS-1:0] r_sync0;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_n;
    logic [GW-1:0]       r_cnt [CHANNELS];
    logic [CHANNELS-1:0] r_held;

    // r_n is registered so the press/release latency is G+2 edges after E0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync0            <= IDLE;
            r_sync1            <= IDLE;
            r_n                <= '0;
            key_state_o        <= '0;
            key_pressed_stb_o  <= '0;
            key_released_stb_o <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            r_sync0 <= key_i;
            r_sync1 <= r_sync0;
            r_n     <= (ACTIVE_LOW != 0) ? ~r_sync1 : r_sync1;
            for (int c = 0; c < CHANNELS; c++) begin
                key_pressed_stb_o[c]  <= 1'b0;
                key_released_stb_o[c] <= 1'b0;
                if (r_n[c] == key_state_o[c]) begin
                    r_cnt[c] <= '0;
                end else if (r_cnt[c] == G_LAST) begin
                    r_cnt[c]              <= '0;
                    key_state_o[c]        <= r_n[c];
                    key_pressed_stb_o[c]  <= r_n[c];
                    key_released_stb_o[c] <= ~r_n[c];
                end else begin
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    end

    generate
        if (H > 0) begin : g_hold
            localparam int HW = $clog2(H + 1);
            localparam logic [HW-1:0] H_MAX = HW'(H);
            localparam logic [HW-1:0] H_PRE = HW'(H - 1);

            logic [HW-1:0] r_hcnt [CHANNELS];

            // saturating at H keeps the strobe from re-firing on a long hold
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_held <= '0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_hcnt[c] <= '0;
                    end
                end else begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_held[c] <= 1'b0;
                        if (!key_state_o[c]) begin
                            r_hcnt[c] <= '0;
                        end else if (r_hcnt[c] != H_MAX) begin
                            r_hcnt[c] <= r_hcnt[c] + 1'b1;
                            r_held[c] <= (r_hcnt[c] == H_PRE);
                        end
                    end
                end
            end
        end else begin : g_nohold
            assign r_held = '0;
        end
    endgenerate

    assign key_held_stb_o = r_held;

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: an active-low instance with H=100
// and an active-high instance with the hold feature disabled.
module tb_debouncer_multi;

    logic       clk;
    logic       rst;
    logic [3:0] kA, kB;
    logic [3:0] a_state, a_press, a_rel, a_held;
    logic [3:0] b_state, b_press, b_rel, b_held;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int pcnt [4], rcnt [4], hcnt [4];
    int pedge [4], redge [4], hedge [4];
    int both = 0, st_tog = 0, st_edge = 0;
    logic st_prev = 1'b0;
    logic [3:0] last_pmask = '0, last_rmask = '0;
    int b_pcnt = 0, b_rcnt = 0, b_hcnt = 0, b_pedge = 0, b_redge = 0;

    debouncer_multi #(
        .CHANNELS(4), .CLK_FREQ_MHZ(100), .GLITCH_TIME_NS(150),
        .ACTIVE_LOW(1), .HOLD_TIME_US(1)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .key_i(kA),
        .key_state_o(a_state), .key_pressed_stb_o(a_press),
        .key_released_stb_o(a_rel), .key_held_stb_o(a_held)
    );

    debouncer_multi #(
        .CHANNELS(4), .CLK_FREQ_MHZ(100), .GLITCH_TIME_NS(150),
        .ACTIVE_LOW(0), .HOLD_TIME_US(0)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .key_i(kB),
        .key_state_o(b_state), .key_pressed_stb_o(b_press),
        .key_released_stb_o(b_rel), .key_held_stb_o(b_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // edge-stamped event log; cyc is the number of the edge just passed
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (a_press[c]) begin pcnt[c]++; pedge[c] = cyc; end
            if (a_rel[c])   begin rcnt[c]++; redge[c] = cyc; end
            if (a_held[c])  begin hcnt[c]++; hedge[c] = cyc; end
        end
        if ((a_press & a_rel) != 4'h0) both++;
        if ((b_press & b_rel) != 4'h0) both++;
        if (a_press != 4'h0) last_pmask = a_press;
        if (a_rel != 4'h0) last_rmask = a_rel;
        if (a_state[0] != st_prev) begin st_tog++; st_edge = cyc; end
        st_prev = a_state[0];
        if (b_press[0]) begin b_pcnt++; b_pedge = cyc; end
        if (b_rel[0])   begin b_rcnt++; b_redge = cyc; end
        if (b_held != 4'h0) b_hcnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_pulse(input bit on_b, input int len);
        int e0, p0, r0;
        string t;
        t  = $sformatf("%s_len%0d", on_b ? "b" : "a", len);
        p0 = on_b ? b_pcnt : pcnt[0];
        r0 = on_b ? b_rcnt : rcnt[0];
        e0 = cyc + 1;
        if (on_b) kB[0] = 1'b1; else kA[0] = 1'b0;
        repeat (len) tick();
        if (on_b) kB[0] = 1'b0; else kA[0] = 1'b1;
        repeat (40) tick();
        if (len >= 15) begin
            check({t, "_pcnt"}, (on_b ? b_pcnt : pcnt[0]) - p0, 1);
            check({t, "_plat"}, (on_b ? b_pedge : pedge[0]) - e0, 17);
            check({t, "_rcnt"}, (on_b ? b_rcnt : rcnt[0]) - r0, 1);
            check({t, "_rlat"}, (on_b ? b_redge : redge[0]) - (e0 + len), 17);
        end else begin
            check({t, "_pcnt"}, (on_b ? b_pcnt : pcnt[0]) - p0, 0);
            check({t, "_rcnt"}, (on_b ? b_rcnt : rcnt[0]) - r0, 0);
        end
    endtask

    int e0, f0, p0, r0, h0, t0;
    int a_lens [5] = '{1, 14, 15, 16, 60};
    int b_lens [3] = '{14, 15, 150};

    initial begin
        for (int c = 0; c < 4; c++) begin
            pcnt[c] = 0; rcnt[c] = 0; hcnt[c] = 0;
            pedge[c] = 0; redge[c] = 0; hedge[c] = 0;
        end
        rst = 1'b1;
        kA  = 4'hF;
        kB  = 4'h0;
        tick();
        tick();
        check("rst_a", 32'({a_state, a_press, a_rel, a_held}), 32'h0);
        check("rst_b", 32'({b_state, b_press, b_rel, b_held}), 32'h0);
        rst = 1'b0;
        repeat (5) tick();
        check("idle_a", 32'({a_state, a_press, a_rel, a_held}), 32'h0);

        foreach (a_lens[i]) run_pulse(1'b0, a_lens[i]);

        // bounce train: 3-cycle toggles, then a steady press
        p0 = pcnt[0];
        t0 = st_tog;
        for (int i = 0; i < 20; i++) begin
            kA[0] = i[0];
            repeat (3) tick();
        end
        kA[0] = 1'b0;
        e0 = cyc + 1;
        repeat (20) tick();
        check("bounce_pcnt", pcnt[0] - p0, 1);
        check("bounce_plat", pedge[0] - e0, 17);
        check("bounce_tog", st_tog - t0, 1);
        check("bounce_togedge", st_edge - e0, 17);
        kA[0] = 1'b1;
        repeat (40) tick();

        // all channels on one edge, then channel 2 alone
        p0 = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
        kA = 4'h0;
        e0 = cyc + 1;
        repeat (25) tick();
        check("multi_pmask", 32'(last_pmask), 32'hF);
        check("multi_pcnt", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] - p0, 4);
        check("multi_plat", pedge[3] - e0, 17);
        r0 = rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3];
        kA = 4'b0100;
        e0 = cyc + 1;
        repeat (25) tick();
        check("multi_rmask", 32'(last_rmask), 32'h4);
        check("multi_rcnt", rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3] - r0, 1);
        check("multi_rlat", redge[2] - e0, 17);
        kA = 4'hF;
        repeat (40) tick();

        // long press, twice
        h0 = hcnt[0];
        kA[0] = 1'b0;
        repeat (300) tick();
        check("hold1_cnt", hcnt[0] - h0, 1);
        check("hold1_lat", hedge[0] - pedge[0], 100);
        kA[0] = 1'b1;
        repeat (40) tick();
        check("hold1_nomore", hcnt[0] - h0, 1);
        kA[0] = 1'b0;
        repeat (150) tick();
        check("hold2_cnt", hcnt[0] - h0, 2);
        check("hold2_lat", hedge[0] - pedge[0], 100);
        kA[0] = 1'b1;
        repeat (40) tick();

        // reset with ch1 accepted and ch0 mid-count (counter at 10)
        kA[1] = 1'b0;
        repeat (30) tick();
        r0 = rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3];
        p0 = pcnt[0] + pcnt[1];
        kA[0] = 1'b0;
        repeat (13) tick();
        rst = 1'b1;
        #1;
        check("rstmid_a", 32'({a_state, a_press, a_rel, a_held}), 32'h0);
        tick();
        check("rstmid_hold", 32'({a_state, a_press, a_rel, a_held}), 32'h0);
        tick();
        rst = 1'b0;
        f0 = cyc + 1;
        repeat (25) tick();
        check("rstmid_pmask", 32'(last_pmask), 32'h3);
        check("rstmid_plat0", pedge[0] - f0, 17);
        check("rstmid_plat1", pedge[1] - f0, 17);
        check("rstmid_pcnt", pcnt[0] + pcnt[1] - p0, 2);
        check("rstmid_norel", rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3] - r0, 0);
        kA = 4'hF;
        repeat (40) tick();

        foreach (b_lens[i]) run_pulse(1'b1, b_lens[i]);

        check("b_held_zero", b_hcnt, 0);
        check("press_rel_overlap", both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
